pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline buffers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.

---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline buffers and PC,
// with load-use detection, memory-wait freeze, MEM-stage redirect, halt/drain and perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MAX_WAIT     = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [4:0]       rs_num_ID,
  input  logic [4:0]       rt_num_ID,
  input  logic             uses_rs_ID,
  input  logic             uses_rt_ID,
  input  logic             mem_read_EX,
  input  logic [4:0]       rd_num_EX,
  input  logic             branch_taken_MEM,
  input  logic             jump_MEM,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             halt_ack,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state_q, state_d, ret_q, ret_d, eff;
  logic [WW-1:0] wait_q, wait_d;
  logic [DW-1:0] drain_q, drain_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic frz, redirect, loaduse, pc_we_c, ack_c;
  logic [3:0] stall_c, flush_c;
  assign redirect = branch_taken_MEM | jump_MEM;
  assign loaduse = mem_read_EX && rd_num_EX != 5'd0 &&
                   ((uses_rs_ID && rs_num_ID == rd_num_EX) || (uses_rt_ID && rt_num_ID == rd_num_EX));
  // Once memory is ready, MEM_WAIT behaves as the state it interrupted for that cycle.
  assign eff = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign frz = dmem_req_MEM & ~dmem_ready & (eff != HALTED);
  always_comb begin
    pc_we_c = 1'b1;
    stall_c = 4'b0000;
    flush_c = 4'b0000;
    ack_c   = 1'b0;
    state_d = eff;
    ret_d   = ret_q;
    drain_d = drain_q;
    if (eff == HALTED) begin
      pc_we_c = 1'b0;
      stall_c = 4'b1111;
      ack_c   = 1'b1;
      state_d = halt_req ? HALTED : RUN;
    end else if (frz) begin
      pc_we_c = 1'b0;
      stall_c = 4'b1111;
      state_d = MEM_WAIT;
      ret_d   = eff;
    end else begin
      if (redirect) begin
        flush_c = 4'b1110;
      end else if (loaduse) begin
        pc_we_c = 1'b0;
        stall_c = 4'b1000;
        flush_c = 4'b0100;
      end else if (eff == DRAIN) begin
        pc_we_c = 1'b0;
        flush_c = 4'b1000;
      end
      if (eff == RUN) begin
        if (halt_req) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end else if (!halt_req) begin
        state_d = RUN;
      end else if (redirect) begin
        drain_d = '0;
      end else if (!loaduse) begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = HALTED;
          drain_d = '0;
        end
      end
    end
    wait_d      = frz ? ((wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1) : '0;
    timeout_d   = timeout_q | (frz && wait_q >= WW'(MAX_WAIT - 1));
    stall_cnt_d = stall_cnt_q + CNT_W'((|stall_c) & ~(&stall_cnt_q));
    flush_cnt_d = flush_cnt_q + CNT_W'((|flush_c) & ~(&flush_cnt_q));
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      wait_q      <= '0;
      drain_q     <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      wait_q      <= wait_d;
      drain_q     <= drain_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  // Control outputs are forced quiet for as long as reset is held.
  assign pc_we = pc_we_c & rst_b;
  assign {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = stall_c & {4{rst_b}};
  assign {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB} = flush_c & {4{rst_b}};
  assign halt_ack     = ack_c & rst_b;
  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
endmodule
